// File: rtl/pcm_mm_master.sv
// Avalon-MM initiator that fills a PCM word range with an incrementing pattern
// or reads it back and counts mismatches. Accesses are issued from registers one cycle after the FSM decides them.
module pcm_mm_master #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic              hold,
    output logic [ADDR_W-1:0] mm_address,
    output logic              mm_chipselect,
    output logic              mm_clken,
    output logic              mm_write,
    output logic [DATA_W-1:0] mm_writedata,
    output logic [1:0]        mm_byteenable,
    input  logic [DATA_W-1:0] mm_readdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  err_count,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_VREAD  = 3'd2;
    localparam logic [2:0] S_VDRAIN = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] seed_q;

    logic              cs_q, we_q, done_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, pat_q;

    logic              rd_pend_q;
    logic [DATA_W-1:0] rd_exp_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              err_q;
    logic [LEN_W-1:0]  err_cnt_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              accept_s, last_s, mismatch_s;
    logic              iss_cs_s, iss_we_s;
    logic [ADDR_W-1:0] iss_addr_s, addr_k_s;
    logic [DATA_W-1:0] iss_data_s, iss_pat_s, pat_k_s;

    assign accept_s   = cmd_valid && cmd_ready;
    assign addr_k_s   = base_q + ADDR_W'(k_q);
    assign pat_k_s    = seed_q + DATA_W'(k_q);
    assign last_s     = (k_q == (len_q - LEN_W'(1)));
    assign mismatch_s = rd_pend_q && (mm_readdata != rd_exp_q);

    // Next-state and access-decision logic
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        iss_cs_s   = 1'b0;
        iss_we_s   = 1'b0;
        iss_addr_s = {ADDR_W{1'b0}};
        iss_data_s = {DATA_W{1'b0}};
        iss_pat_s  = {DATA_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    k_d = {LEN_W{1'b0}};
                    if ((cmd_len == {LEN_W{1'b0}}) || cmd_op[1]) begin
                        state_d = S_DONE;
                    end else if (cmd_op[0]) begin
                        state_d = S_VREAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                iss_cs_s   = 1'b1;
                iss_we_s   = 1'b1;
                iss_addr_s = addr_k_s;
                iss_data_s = pat_k_s;
                iss_pat_s  = pat_k_s;
                k_d        = k_q + LEN_W'(1);
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_VREAD: begin
                iss_cs_s   = 1'b1;
                iss_addr_s = addr_k_s;
                iss_pat_s  = pat_k_s;
                k_d        = k_q + LEN_W'(1);
                if (last_s) begin
                    state_d = S_VDRAIN;
                end else begin
                    state_d = S_VREAD;
                end
            end
            S_VDRAIN: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM, command latch and registered bus outputs; everything freezes under hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= {LEN_W{1'b0}};
            base_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            seed_q  <= {DATA_W{1'b0}};
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            pat_q   <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!hold) begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept_s) begin
                base_q <= cmd_base;
                len_q  <= cmd_len;
                seed_q <= cmd_seed;
            end
            cs_q    <= iss_cs_s;
            we_q    <= iss_we_s;
            addr_q  <= iss_addr_s;
            wdata_q <= iss_data_s;
            pat_q   <= iss_pat_s;
            done_q  <= (state_q == S_DONE);
            busy_q  <= (state_q != S_IDLE);
        end
    end

    // Read-compare pipeline: data returns on the first unheld cycle after the issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_exp_q   <= {DATA_W{1'b0}};
            rd_addr_q  <= {ADDR_W{1'b0}};
            err_q      <= 1'b0;
            err_cnt_q  <= {LEN_W{1'b0}};
            err_addr_q <= {ADDR_W{1'b0}};
        end else if (!hold) begin
            rd_pend_q <= cs_q && !we_q;
            rd_exp_q  <= pat_q;
            rd_addr_q <= addr_q;
            if (accept_s) begin
                err_q      <= 1'b0;
                err_cnt_q  <= {LEN_W{1'b0}};
                err_addr_q <= {ADDR_W{1'b0}};
            end else if (mismatch_s) begin
                err_q <= 1'b1;
                if (err_cnt_q != {LEN_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + LEN_W'(1);
                end
                if (!err_q) begin
                    err_addr_q <= rd_addr_q;
                end
            end
        end
    end

    assign cmd_ready     = (state_q == S_IDLE) && !hold;
    assign mm_chipselect = cs_q && !hold;
    assign mm_write      = we_q && !hold;
    assign mm_clken      = !hold;
    assign mm_address    = addr_q;
    assign mm_writedata  = wdata_q;
    assign mm_byteenable = 2'b11;
    assign done          = done_q && !hold;
    assign busy          = busy_q || (state_q != S_IDLE);
    assign err           = err_q;
    assign err_count     = err_cnt_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_pcm_mm_master.sv
// Scoreboard bench for pcm_mm_master: stimulus queues expected accesses and
// completions, a negedge monitor pops and compares them against a model memory.
module tb_pcm_mm_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [10:0] cmd_base = 11'h000;
    logic [11:0] cmd_len = 12'h000;
    logic [15:0] cmd_seed = 16'h0000;
    logic        hold = 1'b0;
    logic [10:0] mm_address;
    logic        mm_chipselect, mm_clken, mm_write;
    logic [15:0] mm_writedata;
    logic [1:0]  mm_byteenable;
    logic [15:0] mm_readdata;
    logic        busy, done, err;
    logic [11:0] err_count;
    logic [10:0] err_addr;

    pcm_mm_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .hold(hold), .mm_address(mm_address), .mm_chipselect(mm_chipselect),
        .mm_clken(mm_clken), .mm_write(mm_write), .mm_writedata(mm_writedata),
        .mm_byteenable(mm_byteenable), .mm_readdata(mm_readdata), .busy(busy),
        .done(done), .err(err), .err_count(err_count), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model PCM: registered read, latency 1, frozen while clken is low; poke corrupts a word
    logic [15:0] mem [0:2047];
    logic [15:0] rdata_r = 16'h0000;
    logic        poke_en = 1'b0;
    logic [10:0] poke_addr = 11'h000;
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= mem[poke_addr] ^ 16'h00F0;
        else if (mm_clken && mm_chipselect) begin
            if (mm_write) mem[mm_address] <= mm_writedata;
            else rdata_r <= mem[mm_address];
        end
    end
    assign mm_readdata = rdata_r;

    typedef struct { logic we; logic [10:0] addr; logic [15:0] data; } acc_t;
    typedef struct { int acc; int lat; logic e; logic [11:0] cnt; logic [10:0] eaddr; } dn_t;
    acc_t acc_q[$];
    dn_t  dn_q[$];
    int pass_n = 0;
    int tot_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every bus access and every done pulse must match the head of its queue
    always @(negedge clk) begin
        if (reset_n) begin
            if (hold) chk("hold_quiet", {30'd0, mm_clken, mm_chipselect}, 32'd0);
            else chk("clken_on", {31'd0, mm_clken}, 32'd1);
            if (mm_chipselect) begin
                if (acc_q.size() == 0) begin
                    tot_n++;
                    $display("FAIL unexpected_access: addr %0h at cycle %0d, none expected", mm_address, cyc);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("acc_write", {31'd0, mm_write}, {31'd0, e.we});
                    chk("acc_addr", {21'd0, mm_address}, {21'd0, e.addr});
                    chk("acc_be", {30'd0, mm_byteenable}, 32'd3);
                    if (e.we) chk("acc_wdata", {16'd0, mm_writedata}, {16'd0, e.data});
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    tot_n++;
                    $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("done_latency", cyc - d.acc, d.lat);
                    chk("err", {31'd0, err}, {31'd0, d.e});
                    chk("err_count", {20'd0, err_count}, {20'd0, d.cnt});
                    chk("err_addr", {21'd0, err_addr}, {21'd0, d.eaddr});
                end
            end
        end
    end

    // Issue one command at posedge+1 and wait (bounded) for its completion
    task automatic run_cmd(input logic [1:0] op, input logic [10:0] base, input logic [11:0] len,
                           input logic [15:0] seed, input int lat, input logic e_err,
                           input logic [11:0] e_cnt, input logic [10:0] e_eaddr,
                           input int hold_at, input int abort_at);
        int a, off, n_acc;
        acc_t x;
        dn_t d;
        n_acc = (op[1] == 1'b1) ? 0 : int'(len);
        if (abort_at >= 0) n_acc = abort_at - 2;
        for (int k = 0; k < n_acc; k++) begin
            x.we = (op == 2'b00);
            x.addr = base + 11'(k);
            x.data = seed + 16'(k);
            acc_q.push_back(x);
        end
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_base = base; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1;
        a = cyc;
        if (abort_at < 0) begin
            d.acc = a; d.lat = lat; d.e = e_err; d.cnt = e_cnt; d.eaddr = e_eaddr;
            dn_q.push_back(d);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            off = cyc - a;
            if (off == hold_at) hold = 1'b1;
            if (off == hold_at + 3) hold = 1'b0;
            if (off == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk("abort_cs", {31'd0, mm_chipselect}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_addr", {21'd0, mm_address}, 32'd0);
                chk("abort_err", {19'd0, err, err_count}, 32'd0);
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(negedge clk);
                chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
                @(posedge clk); #1;
                break;
            end
            if (dn_q.size() == 0 && acc_q.size() == 0) break;
            @(posedge clk); #1;
        end
        hold = 1'b0;
        if (dn_q.size() != 0 || acc_q.size() != 0) begin
            tot_n++;
            $display("FAIL timeout: %0d accesses and %0d completions still pending", acc_q.size(), dn_q.size());
            acc_q.delete();
            dn_q.delete();
        end
    endtask

    task automatic poke(input logic [10:0] addr);
        poke_addr = addr; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'd0, mm_chipselect}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_err", {19'd0, err, err_count}, 32'd0);
        chk("rst_addr_data", {5'd0, mm_address, mm_writedata}, 32'd0);
        chk("rst_be", {30'd0, mm_byteenable}, 32'd3);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // basic fill, then wrap-around fill and verify
        run_cmd(2'b00, 11'h010, 12'd4, 16'hA000, 6, 1'b0, 12'd0, 11'h000, -1, -1);
        run_cmd(2'b00, 11'h7FE, 12'd4, 16'hFFFF, 6, 1'b0, 12'd0, 11'h000, -1, -1);
        run_cmd(2'b01, 11'h7FE, 12'd4, 16'hFFFF, 7, 1'b0, 12'd0, 11'h000, -1, -1);

        // corrupted offsets 2 and 5, unheld and then with a 3-cycle hold mid-read
        run_cmd(2'b00, 11'h200, 12'd8, 16'h1234, 10, 1'b0, 12'd0, 11'h000, -1, -1);
        poke(11'h202);
        poke(11'h205);
        run_cmd(2'b01, 11'h200, 12'd8, 16'h1234, 11, 1'b1, 12'd2, 11'h202, -1, -1);
        run_cmd(2'b01, 11'h200, 12'd8, 16'h1234, 14, 1'b1, 12'd2, 11'h202, 4, -1);

        // zero length and reserved op: no access, err cleared by the accept
        run_cmd(2'b00, 11'h050, 12'd0, 16'h0000, 2, 1'b0, 12'd0, 11'h000, -1, -1);
        run_cmd(2'b01, 11'h200, 12'd8, 16'h1234, 11, 1'b1, 12'd2, 11'h202, -1, -1);
        run_cmd(2'b11, 11'h060, 12'd5, 16'h0000, 2, 1'b0, 12'd0, 11'h000, -1, -1);

        // reset while FILL presents k=3, then normal operation resumes
        run_cmd(2'b00, 11'h100, 12'd8, 16'h0000, 0, 1'b0, 12'd0, 11'h000, -1, 5);
        run_cmd(2'b00, 11'h300, 12'd2, 16'h5555, 4, 1'b0, 12'd0, 11'h000, -1, -1);
        run_cmd(2'b01, 11'h300, 12'd2, 16'h5555, 5, 1'b0, 12'd0, 11'h000, -1, -1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
